mac_accumulator: RTL and testbench

//  Downstream stage of multiplier_set. Each accepted beat carries z signed fixed-point

---
 rtl/mac_accumulator.sv | 141 ++++++++++++++
 tb/tb_mac_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//   Downstream of multiplier_set. Each accepted beat carries z signed
//   fixed-point products. A combinational saturating adder tree reduces the
//   products, and the result is accumulated over cpc beats, seeded with bias.
//   One saturated dot-product is emitted per block through valid/ready.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   prod_set (and bias on the first beat) valid
//   in_ready   a beat can be accepted this cycle
//   prod_set   z packed products, product i at [width*(i+1)-1:width*i]
//   bias       block seed, sampled only when beat_cnt==0
//   out_valid  sum/out_sat hold a completed result
//   out_ready  consumer takes the result this cycle
//   sum        saturated dot-product
//   out_sat    some add in this result's computation saturated
//   beat_cnt   index of the next beat within the current block
// ---------------------------------------------------------------------------

// Two's-complement adder that clamps on overflow. Overflow is only possible
// when both operands have the same sign and the raw result's sign differs.
module mac_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         sat
);
    logic [W-1:0] raw;

    assign raw = a + b;
    assign sat = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    assign r   = !sat     ? raw :
                 a[W-1]   ? {1'b1, {(W-1){1'b0}}} :
                            {1'b0, {(W-1){1'b1}}};
endmodule

module mac_accumulator #(
    parameter int z     = 4,
    parameter int width = 16,
    parameter int cpc   = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [width*z-1:0]                     prod_set,
    input  logic [width-1:0]                       bias,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [width-1:0]                       sum,
    output logic                                   out_sat,
    output logic [(cpc > 1 ? $clog2(cpc) : 1)-1:0] beat_cnt
);
    localparam int             BW   = (cpc > 1) ? $clog2(cpc) : 1;
    localparam logic [BW-1:0]  LAST = BW'(cpc - 1);

    // ------------------------------------------------------------------
    // Adder tree, stored heap-style: node k has children 2k+1 and 2k+2,
    // leaves occupy z-1 .. 2z-2 in product order. With z a power of two
    // this pairs adjacent products first and adjacent results after,
    // i.e. level 0 is 0+1, 2+3, ... and node 0 is the root.
    // ------------------------------------------------------------------
    logic [width-1:0] node [2*z-1];
    logic [z-2:0]     node_sat;
    logic             tree_sat;

    for (genvar gi = 0; gi < z; gi++) begin : g_leaf
        assign node[z-1+gi] = prod_set[gi*width +: width];
    end

    for (genvar gk = 0; gk < z-1; gk++) begin : g_node
        mac_sat_add #(.W(width)) u_add (
            .a   (node[2*gk+1]),
            .b   (node[2*gk+2]),
            .r   (node[gk]),
            .sat (node_sat[gk])
        );
    end

    assign tree_sat = |node_sat;

    // ------------------------------------------------------------------
    // Accumulate step. The first beat of a block seeds from bias and
    // starts a fresh saturation flag, so saturation is never carried
    // across blocks.
    // ------------------------------------------------------------------
    logic [width-1:0] acc;
    logic             sat_acc;
    logic             first;
    logic             last;
    logic             accept;
    logic [width-1:0] base;
    logic [width-1:0] nxt_acc;
    logic             add_sat;
    logic             nxt_sat;

    assign first    = (beat_cnt == '0);
    assign last     = (beat_cnt == LAST);
    assign in_ready = !out_valid || out_ready;   // handoff and accept may coincide
    assign accept   = in_valid && in_ready;
    assign base     = first ? bias : acc;

    mac_sat_add #(.W(width)) u_acc_add (
        .a   (base),
        .b   (node[0]),
        .r   (nxt_acc),
        .sat (add_sat)
    );

    assign nxt_sat = tree_sat | add_sat | (!first && sat_acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt  <= '0;
            acc       <= '0;
            sat_acc   <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                acc      <= nxt_acc;
                sat_acc  <= nxt_sat;
                beat_cnt <= last ? '0 : beat_cnt + 1'b1;
            end
            // A fresh load wins over a same-cycle handoff, keeping out_valid
            // high. Otherwise the output register is held until taken.
            if (accept && last) begin
                sum       <= nxt_acc;
                out_sat   <= nxt_sat;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;
    localparam int W = 16, Z = 4, CPC = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W*Z-1:0] prod_set = '0;
    logic [W-1:0]  bias = '0;
    logic          in_ready, out_valid, out_sat;
    logic [W-1:0]  sum;
    logic [1:0]    beat_cnt;

    mac_accumulator #(.z(Z), .width(W), .cpc(CPC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod_set  (prod_set),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .out_sat   (out_sat),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        f;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    // reference state: beats seen in the current block, running value, flag
    int   mcnt = 0;
    int   macc = 0;
    bit   msat = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Signed add with clamping to the 16-bit range; flags any clamp.
    function automatic int clampv(input int v, inout bit s);
        if (v > 32767)  begin s = 1'b1; return 32767;  end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return v;
    endfunction

    // Pairwise reduction of the four products, clamping every partial sum.
    function automatic void tree_ref(input logic [63:0] p, output int r, output bit s);
        int v[4];
        s = 1'b0;
        for (int i = 0; i < 4; i++) v[i] = int'($signed(p[16*i +: 16]));
        for (int n = 4; n > 1; n = n / 2)
            for (int i = 0; i < n / 2; i++) v[i] = clampv(v[2*i] + v[2*i+1], s);
        r = v[0];
    endfunction

    // One clock of stimulus: drive at negedge, decide acceptance just after.
    task automatic cyc(input bit v, input logic [63:0] p, input logic [15:0] b, input bit ordy);
        int  t;
        bit  s;
        exp_t e;
        @(negedge clk);
        in_valid = v; prod_set = p; bias = b; out_ready = ordy;
        #2;
        if (in_valid && in_ready) begin
            check("beat_cnt", int'(beat_cnt), mcnt);
            tree_ref(p, t, s);
            if (mcnt == 0) begin
                macc = clampv(int'($signed(b)) + t, s);
            end else begin
                s = s | msat;
                macc = clampv(macc + t, s);
            end
            msat = s;
            mcnt++;
            if (mcnt == CPC) begin
                e.s = macc[15:0];
                e.f = msat;
                q.push_back(e);
                pushed++;
                mcnt = 0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            cyc(1'b0, '0, '0, 1'b1);
            n++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
    endtask

    // Runs until one more block completes, with random bubbles/backpressure.
    task automatic rand_block(input logic [63:0] p, input logic [15:0] b, input bit rnd_p);
        int start = pushed;
        int g = 0;
        logic [63:0] pp;
        while (pushed == start && g < 200) begin
            pp = p;
            if (rnd_p) begin
                for (int i = 0; i < 4; i++)
                    pp[16*i +: 16] = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800) - 16'h0400);
            end
            cyc(($urandom % 10) < 7, pp, b, ($urandom % 10) < 7);
            g++;
        end
        if (pushed == start) begin
            total++; bad++;
            $display("FAIL block_timeout: got %0d blocks want %0d", pushed, start + 1);
        end
    endtask

    // Monitor: pops an expectation whenever a result is handed off.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: got sum %0h want none", sum);
                end else begin
                    e = q.pop_front();
                    check("sum", int'(sum), int'(e.s));
                    check("out_sat", int'(out_sat), int'(e.f));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        check("rst_beat_cnt", int'(beat_cnt), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk); #1 reset_n = 1'b1;

        // 1: 4 x 1.0 per beat over 4 beats -> 16.0, 1 clk latency
        repeat (3) cyc(1'b1, {4{16'h0400}}, 16'h0000, 1'b1);
        cyc(1'b1, {4{16'h0400}}, 16'h0000, 1'b1);
        check("t1_no_early_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("t1_latency", int'(out_valid), 1);
        check("t1_sum", int'(sum), 16'h4000);
        drain();

        // 2: tree clamps positive on the first beat
        cyc(1'b1, {4{16'h7000}}, 16'h0400, 1'b1);
        repeat (3) cyc(1'b1, '0, 16'h0000, 1'b1);
        drain();

        // 3: negative clamp, then a clean block must report no saturation
        repeat (4) cyc(1'b1, {4{16'h9000}}, 16'h0000, 1'b1);
        repeat (4) cyc(1'b1, {4{16'h0100}}, 16'h0000, 1'b1);
        drain();

        // 4: backpressure holds the result and blocks input
        repeat (4) cyc(1'b1, {4{16'h0100}}, 16'h0000, 1'b0);
        repeat (10) begin
            cyc(1'b1, {4{16'h0100}}, 16'h0000, 1'b0);
            check("t4_in_ready_low", int'(in_ready), 0);
            check("t4_sum_hold", int'(sum), 16'h1000);
            check("t4_valid_hold", int'(out_valid), 1);
        end
        cyc(1'b1, {4{16'h0100}}, 16'h0000, 1'b1);
        check("t4_same_cycle_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        check("t4_accept_on_handoff", int'(beat_cnt), 1);
        repeat (3) cyc(1'b1, {4{16'h0100}}, 16'h0000, 1'b1);
        drain();

        // 5: mixed-sign products with random bubbles
        repeat (3) rand_block({16'h0000, 16'h0200, 16'hFC00, 16'h0400},
                              16'($urandom_range(0, 16'h2000) - 16'h1000), 1'b0);
        drain();

        // random blocks, random data and handshake
        repeat (40) rand_block('0, 16'($urandom), 1'b1);
        drain();

        // 6: async reset in the middle of a block
        repeat (2) cyc(1'b1, {4{16'h0300}}, 16'h0123, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("t6_beat_cnt", int'(beat_cnt), 0);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_sum", int'(sum), 0);
        check("t6_out_sat", int'(out_sat), 0);
        mcnt = 0; macc = 0; msat = 0;
        #2 reset_n = 1'b1;
        repeat (4) cyc(1'b1, {4{16'h0400}}, 16'h0100, 1'b1);
        @(posedge clk); #1;
        check("t6_clean_sum", int'(sum), 16'h4100);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
